// File: rtl/peripheral_spram_arbiter_pkg.sv
// Shared types and constants for the two-port single-port-RAM arbiter.
// Port identifiers, idle pin levels and the byte-enable to write-enable mapping.
package peripheral_spram_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    localparam logic       RAM_CEN_OFF = 1'b1;
    localparam logic [1:0] RAM_WEN_OFF = 2'b11;

    // Requesters use active-high byte strobes; the macro wants active-low lanes.
    function automatic logic [1:0] be_to_wen(input logic [1:0] be);
        return ~be;
    endfunction

endpackage

// File: rtl/peripheral_spram_arbiter_if.sv
// Requester-side bus of the SPRAM arbiter: request/grant plus read-return strobe.
// "master" is the requester's view; "slave" is the arbiter's view.
interface peripheral_spram_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          req;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/peripheral_spram_arbiter_core.sv
// Grant decision for two requesters: round-robin, or fixed priority to A
// with a starvation guard that forces a B grant after STARVE_LIMIT denials.
module peripheral_spram_arb_core
    import peripheral_spram_pkg::*;
#(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    port_id_e      last_winner;
    logic [SW-1:0] starve_cnt;
    logic          b_wins_tie;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        b_wins_tie = (PRIO_MODE == 0) ? (last_winner == PORT_A)
                                      : (starve_cnt == STARVE_MAX);
        a_gnt = a_req && !(b_req && b_wins_tie);
        b_gnt = b_req && !(a_req && !b_wins_tie);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= PORT_B;
            starve_cnt  <= '0;
        end else begin
            if (a_gnt) begin
                last_winner <= PORT_A;
            end else if (b_gnt) begin
                last_winner <= PORT_B;
            end

            if (PRIO_MODE == 0 || !b_req || b_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_spram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM (1-cycle read latency).
// Drives the RAM pins from the winner and returns read data to the owning port.
module peripheral_spram_arbiter
    import peripheral_spram_pkg::*;
#(
    parameter int AW           = 6,
    parameter int DW           = 16,
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      soc_ram_clk,
    input  logic                      soc_ram_rst_n,
    peripheral_spram_arbiter_if.slave a,
    peripheral_spram_arbiter_if.slave b,
    output logic [AW-1:0]             soc_ram_addr,
    output logic [DW-1:0]             soc_ram_din,
    output logic                      soc_ram_cen,
    output logic [1:0]                soc_ram_wen,
    input  logic [DW-1:0]             soc_ram_dout
);
    logic     a_gnt, b_gnt;
    logic     a_rvalid, b_rvalid;
    logic [1:0] win_be;
    logic     rd_pend;
    port_id_e rd_owner;

    peripheral_spram_arb_core #(
        .PRIO_MODE    (PRIO_MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_core (
        .clk   (soc_ram_clk),
        .rst_n (soc_ram_rst_n),
        .a_req (a.req),
        .b_req (b.req),
        .a_gnt (a_gnt),
        .b_gnt (b_gnt)
    );

    assign a.gnt = a_gnt;
    assign b.gnt = b_gnt;

    always_comb begin
        soc_ram_cen  = RAM_CEN_OFF;
        soc_ram_wen  = RAM_WEN_OFF;
        soc_ram_addr = '0;
        soc_ram_din  = '0;
        win_be       = 2'b00;
        if (a_gnt) begin
            soc_ram_cen  = 1'b0;
            soc_ram_addr = a.addr;
            soc_ram_din  = a.wdata;
            win_be       = a.be;
            soc_ram_wen  = be_to_wen(a.be);
        end else if (b_gnt) begin
            soc_ram_cen  = 1'b0;
            soc_ram_addr = b.addr;
            soc_ram_din  = b.wdata;
            win_be       = b.be;
            soc_ram_wen  = be_to_wen(b.be);
        end
    end

    // Remember who issued a read so the RAM's next-cycle dout is steered back to it.
    always_ff @(posedge soc_ram_clk or negedge soc_ram_rst_n) begin
        if (!soc_ram_rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_A;
        end else begin
            rd_pend  <= (a_gnt || b_gnt) && (win_be == 2'b00);
            rd_owner <= b_gnt ? PORT_B : PORT_A;
        end
    end

    always_comb begin
        a_rvalid = rd_pend && (rd_owner == PORT_A);
        b_rvalid = rd_pend && (rd_owner == PORT_B);
    end

    assign a.rvalid = a_rvalid;
    assign b.rvalid = b_rvalid;
    assign a.rdata  = a_rvalid ? soc_ram_dout : '0;
    assign b.rdata  = b_rvalid ? soc_ram_dout : '0;

endmodule
